ro_sample_collector: RTL

- Downstream consumer of the RO period counter. Takes its 32-bit clk_400m count and its valid level.
- Synchronises valid into clk_400m and captures each new count on the rising edge of valid.
- Averages WIN samples and tracks the window min/max.
- Pushes each window average into a small FIFO. The FIFO is drained by the RAM-write logic over a valid/ready handshake.

---
 rtl/ro_sample_collector.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ro_sample_collector.sv
// Collects RO period counts: synchronises the upstream valid, averages WIN nonzero
// samples per window with min/max tracking, and queues averages in a small FIFO.
module ro_sample_collector #(
    parameter int WIN        = 8,
    parameter int LOG2_WIN   = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk_400m,
    input  logic                rst,
    input  logic [31:0]         cnt_in,
    input  logic                cnt_valid,
    input  logic                clear,
    output logic [31:0]         out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         win_min,
    output logic [31:0]         win_max,
    output logic [LOG2_WIN:0]   sample_cnt,
    output logic                overflow,
    output logic [15:0]         drop_cnt
);
    localparam int DATA_W = 32;
    localparam int SUM_W  = DATA_W + LOG2_WIN;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [LOG2_WIN:0] LAST_CNT = (LOG2_WIN + 1)'(WIN - 1);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

    function automatic logic [DATA_W-1:0] window_avg(input logic [SUM_W-1:0] s);
        return DATA_W'(s >> LOG2_WIN);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              state;
    logic                s1, s2, s3;
    logic                cap_stb;
    logic [DATA_W-1:0]   cap_data;
    logic [SUM_W-1:0]    sum;
    logic [DATA_W-1:0]   cur_min, cur_max;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;

    logic rise, take, push, pop, full, do_push;

    assign rise    = s2 & ~s3;
    assign take    = cap_stb && (cap_data != '0) && !clear;
    assign push    = (state == COMMIT) && !clear;
    assign pop     = out_valid && out_ready && !clear;
    assign full    = (count == FULL_CNT);
    assign do_push = push && (!full || pop);

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    // Synchroniser and capture; untouched by clear so no false edge appears
    always_ff @(posedge clk_400m or negedge rst) begin
        if (!rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            cap_stb  <= 1'b0;
            cap_data <= '0;
        end else begin
            s1      <= cnt_valid;
            s2      <= s1;
            s3      <= s2;
            cap_stb <= rise;
            if (rise)
                cap_data <= cnt_in;
        end
    end

    // Window FSM
    always_ff @(posedge clk_400m or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sum        <= '0;
            cur_min    <= '0;
            cur_max    <= '0;
            sample_cnt <= '0;
            win_min    <= '0;
            win_max    <= '0;
        end else if (clear) begin
            state      <= IDLE;
            sample_cnt <= '0;
            win_min    <= '0;
            win_max    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        sum        <= SUM_W'(cap_data);
                        cur_min    <= cap_data;
                        cur_max    <= cap_data;
                        sample_cnt <= (LOG2_WIN + 1)'(1);
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (take) begin
                        sum        <= sum + SUM_W'(cap_data);
                        if (cap_data < cur_min) cur_min <= cap_data;
                        if (cap_data > cur_max) cur_max <= cap_data;
                        sample_cnt <= sample_cnt + (LOG2_WIN + 1)'(1);
                        if (sample_cnt == LAST_CNT)
                            state <= COMMIT;
                    end
                end
                COMMIT: begin
                    win_min <= cur_min;
                    win_max <= cur_max;
                    // A sample landing on the commit cycle opens the next window
                    if (take) begin
                        sum        <= SUM_W'(cap_data);
                        cur_min    <= cap_data;
                        cur_max    <= cap_data;
                        sample_cnt <= (LOG2_WIN + 1)'(1);
                        state      <= ACCUM;
                    end else begin
                        sample_cnt <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Average FIFO
    always_ff @(posedge clk_400m or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= window_avg(sum);
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc16(drop_cnt);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !pop)
                count <= count + (PTR_W + 1)'(1);
            else if (!do_push && pop)
                count <= count - (PTR_W + 1)'(1);
        end
    end
endmodule
